// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares one asynchronous SRAM between the instruction-fetch port and the
// data-memory port of the pipeline. Only one SRAM access is in flight at a
// time. The data port has priority over the fetch port whenever both request
// while the arbiter is idle.
//
// Every access runs IDLE -> RD/WR (WAIT_CYCLES+1 cycles) -> DONE (1 cycle)
// -> IDLE. The completion pulse goes to the granted requester during DONE.
// A flush seen during an access lets the SRAM cycle finish cleanly but
// suppresses the ack and the read-data update.
//
// Parameters
//   WAIT_CYCLES        extra SRAM access cycles beyond the first (0..7)
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   flush              pipeline flush from the pipeline controller
//   if_req, if_addr    fetch read request and byte address
//   if_rdata, if_ack   fetched word and one-cycle completion pulse
//   mem_req, mem_we, mem_sel, mem_addr, mem_wdata
//                      data request, write enable, byte lanes, address, data
//   mem_rdata, mem_ack loaded word and one-cycle completion pulse
//   stallreq_from_if   fetch port waiting for its ack
//   stallreq_from_mem  data port waiting for its ack
//   sram_addr          SRAM word address (byte address bits 21:2)
//   sram_dq_o/_oe/_i   SRAM data bus out, output enable, data bus in
//   sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
//                      active-low SRAM strobes and byte enables
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,

  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,

  output logic        stallreq_from_if,
  output logic        stallreq_from_mem,

  output logic [19:0] sram_addr,
  output logic [31:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [31:0] sram_dq_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t     state;
  logic       grant_mem;
  logic       drop;
  logic [2:0] wait_cnt;

  // Only the word-address slice of each byte address reaches the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0],
                              mem_addr[31:22], mem_addr[1:0]};

  // A requester stalls the pipeline until the cycle its ack is high.
  assign stallreq_from_if  = if_req  & ~if_ack;
  assign stallreq_from_mem = mem_req & ~mem_ack;

  // Arbitration FSM. All SRAM pins are driven from registers loaded here,
  // so the pins change only on clock edges and never follow the request
  // inputs combinationally. The address, lanes and write data loaded at
  // grant time stay put for the whole access, which is what makes later
  // changes on the request inputs harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_mem  <= 1'b0;
      drop       <= 1'b0;
      wait_cnt   <= 3'd0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= 32'h0;
      mem_rdata  <= 32'h0;
      sram_addr  <= 20'h0;
      sram_dq_o  <= 32'h0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;

      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (!flush && (mem_req || if_req)) begin
            wait_cnt  <= WAIT_INIT;
            sram_ce_n <= 1'b0;
            if (mem_req) begin
              grant_mem <= 1'b1;
              sram_addr <= mem_addr[21:2];
              if (mem_we) begin
                state      <= WR;
                sram_we_n  <= 1'b0;
                sram_oe_n  <= 1'b1;
                sram_be_n  <= ~mem_sel;
                sram_dq_oe <= 1'b1;
                sram_dq_o  <= mem_wdata;
              end else begin
                state      <= RD;
                sram_oe_n  <= 1'b0;
                sram_we_n  <= 1'b1;
                sram_be_n  <= 4'h0;
                sram_dq_oe <= 1'b0;
              end
            end else begin
              grant_mem  <= 1'b0;
              sram_addr  <= if_addr[21:2];
              state      <= RD;
              sram_oe_n  <= 1'b0;
              sram_we_n  <= 1'b1;
              sram_be_n  <= 4'h0;
              sram_dq_oe <= 1'b0;
            end
          end
        end

        // The flush input is folded in directly on the final cycle so a
        // flush arriving exactly then still suppresses the ack and capture.
        RD, WR: begin
          if (flush) begin
            drop <= 1'b1;
          end
          if (wait_cnt == 3'd0) begin
            state      <= DONE;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= 4'hF;
            sram_dq_oe <= 1'b0;
            if (!(drop || flush)) begin
              if (grant_mem) begin
                mem_ack <= 1'b1;
              end else begin
                if_ack <= 1'b1;
              end
              if (state == RD) begin
                if (grant_mem) begin
                  mem_rdata <= sram_dq_i;
                end else begin
                  if_rdata <= sram_dq_i;
                end
              end
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        // No grant here: pending requests are re-arbitrated in the
        // following IDLE cycle, so the data port keeps its priority.
        DONE: begin
          state <= IDLE;
          drop  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed testbench for bus_arbiter with WAIT_CYCLES=1. The cycle in which
// a request is first driven is cycle 0; step() advances to the next edge and
// samples 1 time unit later. A requester drops its request in the cycle it
// sees its ack, as the pipeline would.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stallreq_from_if;
  logic        stallreq_from_mem;
  logic [19:0] sram_addr;
  logic [31:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [31:0] sram_dq_i;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  int test_count = 0;
  int fail_count = 0;

  int          cyc;
  int          oe_low;
  int          we_low;
  int          if_acks;
  int          mem_acks;
  int          if_ack_at;
  int          mem_ack_at;
  bit          stall_gap;
  bit          got_addr;
  bit          got_wr;
  logic [19:0] first_addr;
  logic [3:0]  first_be;
  logic [31:0] first_dq;
  logic        first_dq_oe;

  bus_arbiter #(.WAIT_CYCLES(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_rdata          (if_rdata),
    .if_ack            (if_ack),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_sel           (mem_sel),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_mem (stallreq_from_mem),
    .sram_addr         (sram_addr),
    .sram_dq_o         (sram_dq_o),
    .sram_dq_oe        (sram_dq_oe),
    .sram_dq_i         (sram_dq_i),
    .sram_ce_n         (sram_ce_n),
    .sram_oe_n         (sram_oe_n),
    .sram_we_n         (sram_we_n),
    .sram_be_n         (sram_be_n)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Restarts the per-scenario cycle counter and observations.
  task automatic clearStats();
    cyc         = 0;
    oe_low      = 0;
    we_low      = 0;
    if_acks     = 0;
    mem_acks    = 0;
    if_ack_at   = -1;
    mem_ack_at  = -1;
    stall_gap   = 1'b0;
    got_addr    = 1'b0;
    got_wr      = 1'b0;
    first_addr  = 20'h0;
    first_be    = 4'h0;
    first_dq    = 32'h0;
    first_dq_oe = 1'b0;
  endtask

  // Advances one clock, records what the SRAM side and acks look like,
  // and lets a requester retire its request once acked.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!sram_oe_n) oe_low++;
    if (!sram_ce_n && !got_addr) begin
      got_addr   = 1'b1;
      first_addr = sram_addr;
    end
    if (!sram_we_n) begin
      we_low++;
      if (!got_wr) begin
        got_wr      = 1'b1;
        first_be    = sram_be_n;
        first_dq    = sram_dq_o;
        first_dq_oe = sram_dq_oe;
      end
    end
    if (if_req && !if_ack && !stallreq_from_if) stall_gap = 1'b1;
    if (if_ack && stallreq_from_if) stall_gap = 1'b1;
    if (if_ack) begin
      if_acks++;
      if (if_ack_at < 0) if_ack_at = cyc;
      if_req = 1'b0;
    end
    if (mem_ack) begin
      mem_acks++;
      if (mem_ack_at < 0) mem_ack_at = cyc;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    if_req    = 1'b0;
    if_addr   = 32'h0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    sram_dq_i = 32'h0;
    clearStats();

    // Reset state
    applyStimulus(2);
    checkOutput("rst_ce_n",   32'(sram_ce_n),  32'h1);
    checkOutput("rst_oe_n",   32'(sram_oe_n),  32'h1);
    checkOutput("rst_we_n",   32'(sram_we_n),  32'h1);
    checkOutput("rst_be_n",   32'(sram_be_n),  32'hF);
    checkOutput("rst_dq_oe",  32'(sram_dq_oe), 32'h0);
    checkOutput("rst_addr",   32'(sram_addr),  32'h0);
    checkOutput("rst_dq_o",   sram_dq_o,       32'h0);
    checkOutput("rst_acks",   32'({if_ack, mem_ack}), 32'h0);
    checkOutput("rst_if_rd",  if_rdata,        32'h0);
    checkOutput("rst_mem_rd", mem_rdata,       32'h0);
    rst = 1'b0;
    applyStimulus(1);

    // Single instruction fetch
    clearStats();
    if_req    = 1'b1;
    if_addr   = 32'h0000_0040;
    sram_dq_i = 32'h1234_5678;
    applyStimulus(6);
    checkOutput("if_addr",    32'(first_addr), 32'h0_0010);
    checkOutput("if_oe_low",  oe_low,          2);
    checkOutput("if_we_low",  we_low,          0);
    checkOutput("if_ack_at",  if_ack_at,       3);
    checkOutput("if_acks",    if_acks,         1);
    checkOutput("if_rdata",   if_rdata,        32'h1234_5678);
    checkOutput("if_stall",   32'(stall_gap),  32'h0);

    // Partial-lane data write
    clearStats();
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_sel   = 4'b0011;
    mem_addr  = 32'h0000_0104;
    mem_wdata = 32'hAABB_CCDD;
    applyStimulus(6);
    checkOutput("wr_we_low",  we_low,          2);
    checkOutput("wr_oe_low",  oe_low,          0);
    checkOutput("wr_be_n",    32'(first_be),   32'hC);
    checkOutput("wr_dq_o",    first_dq,        32'hAABB_CCDD);
    checkOutput("wr_dq_oe",   32'(first_dq_oe), 32'h1);
    checkOutput("wr_addr",    32'(first_addr), 32'h0_0041);
    checkOutput("wr_ack_at",  mem_ack_at,      3);
    checkOutput("wr_acks",    mem_acks,        1);
    checkOutput("wr_if_acks", if_acks,         0);

    // Simultaneous requests: data port first, fetch re-arbitrated after DONE
    clearStats();
    sram_dq_i = 32'h1111_2222;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_sel   = 4'hF;
    mem_addr  = 32'h0000_0200;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0300;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cyc == 3) sram_dq_i = 32'h3333_4444;
    end
    checkOutput("both_addr",   32'(first_addr), 32'h0_0080);
    checkOutput("both_mem_at", mem_ack_at,      3);
    checkOutput("both_if_at",  if_ack_at,       7);
    checkOutput("both_mem_rd", mem_rdata,       32'h1111_2222);
    checkOutput("both_if_rd",  if_rdata,        32'h3333_4444);
    checkOutput("both_oe_low", oe_low,          4);
    checkOutput("both_stall",  32'(stall_gap),  32'h0);

    // Flush during the first read cycle of a fetch
    clearStats();
    sram_dq_i = 32'hDEAD_BEEF;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0044;
    step();
    flush  = 1'b1;
    if_req = 1'b0;
    step();
    flush = 1'b0;
    step();
    step();
    checkOutput("fl_oe_low",  oe_low,         2);
    checkOutput("fl_ce_idle", 32'(sram_ce_n), 32'h1);
    checkOutput("fl_if_acks", if_acks,        0);
    checkOutput("fl_if_rd",   if_rdata,       32'h3333_4444);
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h0000_0400;
    applyStimulus(4);
    checkOutput("fl_mem_at",  mem_ack_at,     7);
    checkOutput("fl_mem_rd",  mem_rdata,      32'hDEAD_BEEF);
    checkOutput("fl_if_rd2",  if_rdata,       32'h3333_4444);

    // Reset during the first write cycle
    clearStats();
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_sel   = 4'hF;
    mem_addr  = 32'h0000_0800;
    mem_wdata = 32'h0000_0055;
    step();
    checkOutput("ra_we_on",   32'(sram_we_n),  32'h0);
    rst = 1'b1;
    step();
    rst     = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    checkOutput("ra_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
    checkOutput("ra_be_n",    32'(sram_be_n),  32'hF);
    checkOutput("ra_dq_oe",   32'(sram_dq_oe), 32'h0);
    applyStimulus(4);
    checkOutput("ra_no_ack",  mem_acks,        0);
    checkOutput("ra_mem_rd",  mem_rdata,       32'h0);

    clearStats();
    if_req    = 1'b1;
    if_addr   = 32'h0000_0080;
    sram_dq_i = 32'hCAFE_F00D;
    applyStimulus(6);
    checkOutput("ra_rd_addr", 32'(first_addr), 32'h0_0020);
    checkOutput("ra_rd_at",   if_ack_at,       3);
    checkOutput("ra_rd_data", if_rdata,        32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
